// File: rtl/alu_latency_ctrl.sv
// Multi-cycle ALU latency controller: stalls execute for LAT(class) cycles, then pulses op_done.
// Define ALU_STALL_PERF_EN to build the saturating stall_cnt performance counter.
module alu_latency_ctrl #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8,
  parameter int NUM_CLASSES = 8,
  parameter logic [NUM_CLASSES*CNT_W-1:0] LAT_TABLE =
    {8'd0, 8'd0, 8'd0, 8'd36, 8'd32, 8'd6, 8'd2, 8'd0},
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [CLS_W-1:0]  op_class,
  input  logic              flush,
  input  logic [DATA_W-1:0] res_in,
  output logic              stall,
  output logic              op_done,
  output logic [DATA_W-1:0] res_out,
  output logic [CLS_W-1:0]  busy_class,
  output logic [31:0]       stall_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CLS_W-1:0]   lcls_q, lcls_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]   lat_tbl [NUM_CLASSES];
  logic [CNT_W-1:0]   lat_in, lat_run;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lat
    assign lat_tbl[k] = LAT_TABLE[k*CNT_W +: CNT_W];
  end

  assign lat_in  = lat_tbl[op_class];
  assign lat_run = lat_tbl[lcls_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcls_d  = lcls_q;
    res_d   = res_q;
    stall   = 1'b0;
    op_done = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && lat_in != '0) begin
            stall   = 1'b1;
            cnt_d   = CNT_W'(1);
            lcls_d  = op_class;
            state_d = RUN;
          end
        end
        RUN: begin
          // op_valid is ignored here, so the op still present at completion cannot retrigger
          if (cnt_q < lat_run) begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            op_done = 1'b1;
            res_d   = res_in;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (!rst) begin
      stall   = 1'b0;
      op_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lcls_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcls_q  <= lcls_d;
      res_q   <= res_d;
    end
  end

  assign res_out    = res_q;
  assign busy_class = (state_q == RUN) ? lcls_q : '0;

`ifdef ALU_STALL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_latency_ctrl.sv
// Randomized + directed bench for alu_latency_ctrl against a countdown reference model.
module tb_alu_latency_ctrl;
  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [2:0]  op_class, busy_class;
  logic [31:0] res_in, res_out, stall_cnt;
  logic        stall, op_done;

  always #5 clk = ~clk;

  alu_latency_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_class(op_class), .flush(flush),
    .res_in(res_in), .stall(stall), .op_done(op_done), .res_out(res_out),
    .busy_class(busy_class), .stall_cnt(stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int lat [8] = '{0, 2, 6, 32, 36, 0, 0, 0};

  // model: busy flag, stall cycles still owed after this one, class, captured result
  bit          m_busy = 0;
  int          m_left = 0;
  int          m_cls  = 0;
  logic [31:0] m_res  = '0;
  longint      m_perf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input bit [2:0] c, input bit f, input bit r,
                      input logic [31:0] d, output bit s_obs, output bit d_obs);
    bit e_stall, e_done;
    int e_bcls;
    @(negedge clk);
    op_valid = v; op_class = c; flush = f; rst = r; res_in = d;
    #1;
    e_stall = 0;
    e_done  = 0;
    e_bcls  = m_busy ? m_cls : 0;
    if (r && !f) begin
      if (!m_busy)        e_stall = v && (lat[c] > 0);
      else if (m_left > 0) e_stall = 1;
      else                 e_done  = 1;
    end
    chk("stall", stall, e_stall);
    chk("op_done", op_done, e_done);
    chk("busy_class", busy_class, e_bcls);
    chk("res_out", res_out, m_res);
`ifdef ALU_STALL_PERF_EN
    chk("stall_cnt", stall_cnt, m_perf[31:0]);
`else
    chk("stall_cnt", stall_cnt, 0);
`endif
    s_obs = stall;
    d_obs = op_done;
    if (!r) begin
      m_busy = 0; m_res = '0; m_perf = 0;
    end else begin
      if (e_stall && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (f) m_busy = 0;
      else if (!m_busy) begin
        if (e_stall) begin m_busy = 1; m_left = lat[c] - 1; m_cls = c; end
      end
      else if (m_left > 0) m_left--;
      else begin m_busy = 0; m_res = d; end
    end
  endtask

  initial begin
    bit s, dn;
    int sc, dc;
    logic [9:0] pat;

    rst = 0; op_valid = 0; op_class = 0; flush = 0; res_in = 0;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 32'hDEAD_BEEF, s, dn);
    step(1, 2, 0, 0, 32'hDEAD_BEEF, s, dn);

    // class 0 for five cycles: never stalls
    sc = 0; dc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, $urandom, s, dn);
      sc += s; dc += dn;
    end
    chk("c0_stalls", sc, 0);
    chk("c0_done", dc, 0);

    // class 2: six stall cycles, completion on the seventh
    sc = 0; dc = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 2, 0, 1, (i == 6) ? 32'h1234_5678 : $urandom, s, dn);
      sc += s;
      if (i == 6) dc = dn;
    end
    chk("c2_stalls", sc, 6);
    chk("c2_done", dc, 1);
    step(0, 0, 0, 1, 0, s, dn);
    chk("c2_res", res_out, 32'h1234_5678);

    // class 3 flushed at cnt=10, then a class 1 op
    dc = 0;
    for (int i = 0; i <= 10; i++) begin
      step(1, 3, (i == 10), 1, $urandom, s, dn);
      dc += dn;
      if (i == 10) chk("flush_stall", s, 0);
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 1, $urandom, s, dn);
      dc += dn;
    end
    chk("flush_no_done", dc, 0);
    sc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, $urandom, s, dn);
      sc += s;
    end
    chk("c1_after_flush", sc, 2);

    // class 4 interrupted by reset at cnt=20
    for (int i = 0; i < 20; i++) step(1, 4, 0, 1, $urandom, s, dn);
    step(1, 4, 0, 0, $urandom, s, dn);
    step(0, 0, 0, 1, 0, s, dn);
    chk("rst_res", res_out, 0);
    chk("rst_busy", busy_class, 0);

    // class 1 then class 2 back to back with op_valid held
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, (i < 3) ? 3'd1 : 3'd2, 0, 1, $urandom, s, dn);
      pat[9-i] = s;
    end
    chk("b2b_pattern", pat, 10'b1101111110);
    step(0, 0, 0, 1, 0, s, dn);
`ifdef ALU_STALL_PERF_EN
    chk("b2b_stall_cnt", stall_cnt, 8);
`else
    chk("b2b_stall_cnt", stall_cnt, 0);
`endif

    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, 3'($urandom % 8), ($urandom % 40) == 0,
           ($urandom % 150) != 0, $urandom, s, dn);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
